knn_sample_streamer: RTL and testbench
======================================

Name: knn_sample_streamer

Overview:
- Producer side of the knn_system load handshake (`read_done` / `data_request` / `done` / `inference_done`).
- Reads one input matrix and 2^L labelled training matrices from synchronous sample memories.
- Packs elements into MAX_ELEMENTS-wide bursts and hands them to knn_system one burst at a time.
- Replaces the bench-side loader, so inference runs can be driven from on-chip memory.

Parameters:
- M, 5, matrix rows
- N, 10, matrix columns
- W, 32, element width in bits
- MAX_ELEMENTS, 32, elements per burst
- TYPE_W, 3, class label width
- L, 6, log2 of the number of training samples

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run
- busy  out  1  high from start acceptance until run_done
- run_done  out  1  one-cycle pulse after `inference_done` is seen
- protocol_err  out  1  sticky error flag; cleared on accepted start
- mem_rd_en  out  1  read strobe to the sample memories
- mem_sample  out  L  training sample index for the read
- mem_elem  out  clog2(M*N)  element index for the read
- train_rd_data  in  W  training element; valid 1 cycle after mem_rd_en
- input_rd_data  in  W  input element at mem_elem; valid 1 cycle after mem_rd_en
- type_rd_data  in  TYPE_W  label of mem_sample; valid 1 cycle after mem_rd_en
- read_done  out  1  one-cycle pulse; burst on data outputs is valid
- training_data  out  W*MAX_ELEMENTS  packed training burst
- input_data  out  W*MAX_ELEMENTS  packed input burst
- training_data_type  out  TYPE_W  label of the current sample
- data_request  in  1  knn_system ready for the next burst of the same sample
- done  in  1  knn_system finished the current sample
- inference_done  in  1  knn_system finished all 2^L samples

Behaviour:
- Derived values:
  - E = M*N elements per matrix.
  - B = ceil(E/MAX_ELEMENTS) bursts per sample.
  - Burst b carries elements b*MAX_ELEMENTS up to min(E,(b+1)*MAX_ELEMENTS)-1.
- Packing:
  - Burst slot j occupies bits [(j+1)*W-1 -: W].
  - Unused slots of a partial final burst are driven to zero.
- Reset: state IDLE. All outputs 0, including the data buses, `protocol_err` and the counters. Reset mid-run aborts immediately; no `read_done` is issued afterwards.
- States: IDLE, FETCH, ISSUE, WAIT_REQ, WAIT_DONE, WAIT_INF.
- IDLE:
  - `start` → FETCH with sample=0, burst=0; `busy` rises the next cycle.
  - `start` in any other state is ignored.
- FETCH:
  - Issues k = burst length reads on consecutive cycles; `mem_rd_en` is high for exactly k cycles.
  - Read data is captured one cycle later into slot (elem - b*MAX_ELEMENTS).
  - `type_rd_data` is captured with the first element of burst 0.
  - After the last capture → ISSUE.
- ISSUE:
  - `read_done` = 1 for exactly one cycle.
  - Data buses and `training_data_type` change only during FETCH captures. They are otherwise held, and are stable from `read_done` until the next FETCH.
  - If burst < B-1 → WAIT_REQ, else → WAIT_DONE.
- WAIT_REQ: `data_request` high → burst+1, FETCH. `data_request` is sampled only in this state.
- WAIT_DONE: `done` high → burst=0.
  - If sample < 2^L-1 → sample+1, FETCH.
  - Otherwise → WAIT_INF.
- WAIT_INF: `inference_done` high → `run_done` pulse, return to IDLE, `busy` = 0 the same cycle.
- Protocol errors set `protocol_err`, which stays set until the next accepted `start`; the FSM continues normally:
  - `done` in WAIT_REQ;
  - `inference_done` before WAIT_INF.
- Timing:
  - Start accepted at cycle 0.
  - First `mem_rd_en` at cycle 1.
  - First `read_done` at cycle k+2.
  - The next FETCH begins the cycle after the handshake input is seen.
- Simultaneous `done` and `data_request` in WAIT_DONE: `done` is taken.

Test Plan:
- M=5, N=10, MAX_ELEMENTS=32, L=1; memory element value = sample*100+elem. `start` at cycle 0 → `read_done` at cycle 34 with slots 0..31 = 0..31. After `data_request`, the second burst has slots 0..17 = 32..49 and slots 18..31 = 0.
- Same configuration, `data_request` withheld for 50 cycles → `read_done` not repeated, `mem_rd_en` stays 0, buses hold.
- M=4, N=4, MAX_ELEMENTS=32, L=2 → one burst per sample. Four `read_done` pulses, each followed by waiting for `done`, with labels 3,1,5,2 as in memory. `inference_done` → `run_done` pulse; `busy` falls.
- `done` asserted while in WAIT_REQ → `protocol_err` = 1 and stays set. The next `start` clears it.
- `rst` asserted during the FETCH of sample 1 → next cycle all outputs 0 and state IDLE. A new `start` restarts from sample 0, element 0.
- `start` pulsed while `busy` → ignored; sample count and burst order are unchanged.

Source files
------------

// File: rtl/knn_sample_streamer.sv
// rtl/knn_sample_streamer.sv - reads input/training matrices from sample memory and streams packed bursts to knn_system
module knn_sample_streamer #(
  parameter int M            = 5,
  parameter int N            = 10,
  parameter int W            = 32,
  parameter int MAX_ELEMENTS = 32,
  parameter int TYPE_W       = 3,
  parameter int L            = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           run_done,
  output logic                           protocol_err,
  output logic                           mem_rd_en,
  output logic [L-1:0]                   mem_sample,
  output logic [$clog2(M*N)-1:0]         mem_elem,
  input  logic [W-1:0]                   train_rd_data,
  input  logic [W-1:0]                   input_rd_data,
  input  logic [TYPE_W-1:0]              type_rd_data,
  output logic                           read_done,
  output logic [W*MAX_ELEMENTS-1:0]      training_data,
  output logic [W*MAX_ELEMENTS-1:0]      input_data,
  output logic [TYPE_W-1:0]              training_data_type,
  input  logic                           data_request,
  input  logic                           done,
  input  logic                           inference_done
);

  localparam int E        = M * N;
  localparam int B        = (E + MAX_ELEMENTS - 1) / MAX_ELEMENTS;
  localparam int LAST_LEN = E - (B - 1) * MAX_ELEMENTS;
  localparam int BW       = (B > 1) ? $clog2(B) : 1;
  localparam int CW       = $clog2(MAX_ELEMENTS + 1);
  localparam int EW       = $clog2(M * N);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_REQ, WAIT_DONE, WAIT_INF} state_t;

  state_t                    state, state_nxt;
  logic [L-1:0]              sample;
  logic [BW-1:0]             burst;
  logic [CW-1:0]             rd_cnt, cap_cnt, burst_len;
  logic                      rd_pend;
  logic                      start_acc, last_cap, err_ev, last_burst;
  logic [W*MAX_ELEMENTS-1:0] train_nxt, input_nxt;

  assign last_burst = (burst == BW'(B - 1));
  assign burst_len  = last_burst ? CW'(LAST_LEN) : CW'(MAX_ELEMENTS);
  assign start_acc  = (state == IDLE) && start;
  assign last_cap   = rd_pend && (cap_cnt == burst_len - 1'b1);
  assign err_ev     = ((state == WAIT_REQ) && done) ||
                      (inference_done && (state != IDLE) && (state != WAIT_INF));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = FETCH;
      FETCH:     if (last_cap) state_nxt = ISSUE;
      ISSUE:     state_nxt = last_burst ? WAIT_DONE : WAIT_REQ;
      WAIT_REQ:  if (data_request) state_nxt = FETCH;
      WAIT_DONE: if (done) state_nxt = (sample == {L{1'b1}}) ? WAIT_INF : FETCH;
      WAIT_INF:  if (inference_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // busy drops in the same cycle run_done pulses, so run_done is combinational on inference_done
  always_comb begin
    mem_rd_en  = (state == FETCH) && (rd_cnt < burst_len);
    read_done  = (state == ISSUE);
    run_done   = (state == WAIT_INF) && inference_done;
    busy       = (state != IDLE) && !run_done;
    mem_sample = mem_rd_en ? sample : '0;
    mem_elem   = mem_rd_en ? EW'(int'(burst) * MAX_ELEMENTS + int'(rd_cnt)) : '0;
  end

  // First capture of a burst clears the bus so a short final burst leaves its tail slots at zero
  always_comb begin
    train_nxt = (cap_cnt == '0) ? '0 : training_data;
    input_nxt = (cap_cnt == '0) ? '0 : input_data;
    train_nxt[int'(cap_cnt) * W +: W] = train_rd_data;
    input_nxt[int'(cap_cnt) * W +: W] = input_rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample             <= '0;
      burst              <= '0;
      rd_cnt             <= '0;
      cap_cnt            <= '0;
      rd_pend            <= 1'b0;
      training_data      <= '0;
      input_data         <= '0;
      training_data_type <= '0;
      protocol_err       <= 1'b0;
    end else begin
      rd_pend <= mem_rd_en;
      if (start_acc)   protocol_err <= 1'b0;
      else if (err_ev) protocol_err <= 1'b1;
      if (start_acc) begin
        sample  <= '0;
        burst   <= '0;
        rd_cnt  <= '0;
        cap_cnt <= '0;
      end
      if (mem_rd_en) rd_cnt <= rd_cnt + 1'b1;
      if (rd_pend) begin
        training_data <= train_nxt;
        input_data    <= input_nxt;
        if (burst == '0 && cap_cnt == '0) training_data_type <= type_rd_data;
        cap_cnt <= cap_cnt + 1'b1;
      end
      if (last_cap) begin
        rd_cnt  <= '0;
        cap_cnt <= '0;
      end
      if (state == WAIT_REQ && data_request) burst <= burst + 1'b1;
      if (state == WAIT_DONE && done) begin
        burst <= '0;
        if (sample != {L{1'b1}}) sample <= sample + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_knn_sample_streamer.sv
// tb/tb_knn_sample_streamer.sv - scoreboard bench for knn_sample_streamer in two memory geometries
module tb_knn_sample_streamer;
  localparam int W    = 32;
  localparam int MX   = 32;
  localparam int BUSW = W * MX;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [BUSW-1:0] tr;
    logic [BUSW-1:0] in;
    logic [2:0]      ty;
  } burst_t;

  burst_t qa[$];
  burst_t qb[$];
  burst_t ma, mb;

  function automatic burst_t mk(input int e, input int s, input int b, input logic [2:0] ty);
    burst_t r;
    int el;
    r.tr = '0;
    r.in = '0;
    r.ty = ty;
    for (int j = 0; j < MX; j++) begin
      el = b * MX + j;
      if (el < e) begin
        r.tr[j*W +: W] = W'(s * 100 + el);
        r.in[j*W +: W] = W'(5000 + el);
      end
    end
    return r;
  endfunction

  logic [2:0] lab_a [2];
  logic [2:0] lab_b [4];
  initial begin
    lab_a = '{3'd3, 3'd6};
    lab_b = '{3'd3, 3'd1, 3'd5, 3'd2};
  end

  // instance A: 5x10 matrices, two bursts per sample, two samples
  logic            a_rst, a_start, a_busy, a_run_done, a_err, a_rd_en, a_read_done;
  logic [0:0]      a_sample;
  logic [5:0]      a_elem;
  logic [W-1:0]    a_train_q, a_input_q;
  logic [2:0]      a_type_q, a_type;
  logic [BUSW-1:0] a_train_bus, a_input_bus;
  logic            a_req, a_done, a_inf;

  knn_sample_streamer #(.M(5), .N(10), .W(W), .MAX_ELEMENTS(MX), .TYPE_W(3), .L(1)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .busy(a_busy), .run_done(a_run_done),
    .protocol_err(a_err), .mem_rd_en(a_rd_en), .mem_sample(a_sample), .mem_elem(a_elem),
    .train_rd_data(a_train_q), .input_rd_data(a_input_q), .type_rd_data(a_type_q),
    .read_done(a_read_done), .training_data(a_train_bus), .input_data(a_input_bus),
    .training_data_type(a_type), .data_request(a_req), .done(a_done), .inference_done(a_inf)
  );

  // instance B: 4x4 matrices, one burst per sample, four samples
  logic            b_rst, b_start, b_busy, b_run_done, b_err, b_rd_en, b_read_done;
  logic [1:0]      b_sample;
  logic [3:0]      b_elem;
  logic [W-1:0]    b_train_q, b_input_q;
  logic [2:0]      b_type_q, b_type;
  logic [BUSW-1:0] b_train_bus, b_input_bus;
  logic            b_req, b_done, b_inf;

  knn_sample_streamer #(.M(4), .N(4), .W(W), .MAX_ELEMENTS(MX), .TYPE_W(3), .L(2)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .busy(b_busy), .run_done(b_run_done),
    .protocol_err(b_err), .mem_rd_en(b_rd_en), .mem_sample(b_sample), .mem_elem(b_elem),
    .train_rd_data(b_train_q), .input_rd_data(b_input_q), .type_rd_data(b_type_q),
    .read_done(b_read_done), .training_data(b_train_bus), .input_data(b_input_bus),
    .training_data_type(b_type), .data_request(b_req), .done(b_done), .inference_done(b_inf)
  );

  always @(posedge clk) begin
    if (a_rd_en) begin
      a_train_q <= W'(int'(a_sample) * 100 + int'(a_elem));
      a_input_q <= W'(5000 + int'(a_elem));
      a_type_q  <= lab_a[a_sample];
    end
    if (b_rd_en) begin
      b_train_q <= W'(int'(b_sample) * 100 + int'(b_elem));
      b_input_q <= W'(5000 + int'(b_elem));
      b_type_q  <= lab_b[b_sample];
    end
  end

  task automatic cmp_burst(input string p, input burst_t x, input logic [BUSW-1:0] tr,
                           input logic [BUSW-1:0] in, input logic [2:0] ty);
    for (int j = 0; j < MX; j++) begin
      check($sformatf("%s_train_slot%0d", p, j), 64'(tr[j*W +: W]), 64'(x.tr[j*W +: W]));
      check($sformatf("%s_input_slot%0d", p, j), 64'(in[j*W +: W]), 64'(x.in[j*W +: W]));
    end
    check($sformatf("%s_type", p), 64'(ty), 64'(x.ty));
  endtask

  always @(negedge clk) begin
    if (a_read_done) begin
      if (qa.size() == 0) check("a_unexpected_read_done", 1, 0);
      else begin
        ma = qa.pop_front();
        cmp_burst("a", ma, a_train_bus, a_input_bus, a_type);
      end
    end
    if (b_read_done) begin
      if (qb.size() == 0) check("b_unexpected_read_done", 1, 0);
      else begin
        mb = qb.pop_front();
        cmp_burst("b", mb, b_train_bus, b_input_bus, b_type);
      end
    end
  end

  task automatic wait_rd(input bit ib, output int cyc, output int ens);
    cyc = 0;
    ens = 0;
    while (1) begin
      if (ib ? b_rd_en : a_rd_en) ens++;
      if (ib ? b_read_done : a_read_done) return;
      if (cyc >= 200) begin
        check("read_done_timeout", 0, 1);
        return;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc, ens, n_en, n_rd;
  logic [BUSW-1:0] saved;

  initial begin
    a_rst = 1'b1; a_start = 1'b0; a_req = 1'b0; a_done = 1'b0; a_inf = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_req = 1'b0; b_done = 1'b0; b_inf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", a_busy, 0);
    check("rst_rd_en", a_rd_en, 0);
    check("rst_read_done", a_read_done, 0);
    check("rst_err", a_err, 0);
    check("rst_elem", a_elem, 0);
    check("rst_bus", |{a_train_bus, a_input_bus, a_type}, 0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);

    // run 1: timing, hold, protocol error, ignored start, done+request collision
    qa.push_back(mk(50, 0, 0, 3'd3));
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    check("a_busy_after_start", a_busy, 1);
    check("a_first_rd_en", a_rd_en, 1);
    check("a_first_elem", a_elem, 0);
    wait_rd(0, cyc, ens);
    check("a_first_read_done_cycle", 1 + cyc, 34);
    check("a_burst0_reads", ens, 32);
    saved = a_train_bus;
    n_en = 0; n_rd = 0;
    repeat (50) begin
      @(negedge clk);
      if (a_rd_en) n_en++;
      if (a_read_done) n_rd++;
    end
    check("a_hold_rd_en", n_en, 0);
    check("a_hold_read_done", n_rd, 0);
    check("a_hold_bus", a_train_bus == saved, 1);
    a_done = 1'b1; @(negedge clk); a_done = 1'b0;
    check("a_err_done_in_wait_req", a_err, 1);
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    check("a_start_ignored_busy", a_busy, 1);
    check("a_start_ignored_err", a_err, 1);
    check("a_start_ignored_rd_en", a_rd_en, 0);
    qa.push_back(mk(50, 0, 1, 3'd3));
    a_req = 1'b1; @(negedge clk); a_req = 1'b0;
    wait_rd(0, cyc, ens);
    check("a_burst1_reads", ens, 18);
    check("a_burst1_latency", cyc, 19);
    @(negedge clk);
    qa.push_back(mk(50, 1, 0, 3'd6));
    a_done = 1'b1; @(negedge clk); a_done = 1'b0;
    check("a_s1_sample", a_sample, 1);
    check("a_s1_elem", a_elem, 0);
    wait_rd(0, cyc, ens);
    check("a_s1_burst0_reads", ens, 32);
    @(negedge clk);
    qa.push_back(mk(50, 1, 1, 3'd6));
    a_req = 1'b1; @(negedge clk); a_req = 1'b0;
    check("a_s1_b1_elem", a_elem, 32);
    wait_rd(0, cyc, ens);
    check("a_s1_burst1_reads", ens, 18);
    @(negedge clk);
    a_done = 1'b1; a_req = 1'b1; @(negedge clk); a_done = 1'b0; a_req = 1'b0;
    repeat (3) @(negedge clk);
    check("a_wait_inf_rd_en", a_rd_en, 0);
    check("a_wait_inf_busy", a_busy, 1);
    check("a_err_sticky", a_err, 1);
    a_inf = 1'b1; #1;
    check("a_run_done", a_run_done, 1);
    check("a_busy_falls", a_busy, 0);
    @(negedge clk); a_inf = 1'b0;
    check("a_run_done_pulse", a_run_done, 0);
    check("a_idle_busy", a_busy, 0);
    check("a_err_kept_idle", a_err, 1);

    // run 2: start clears error; reset mid-fetch of sample 1; restart from zero
    qa.push_back(mk(50, 0, 0, 3'd3));
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    check("a_err_cleared", a_err, 0);
    wait_rd(0, cyc, ens);
    @(negedge clk);
    qa.push_back(mk(50, 0, 1, 3'd3));
    a_req = 1'b1; @(negedge clk); a_req = 1'b0;
    wait_rd(0, cyc, ens);
    @(negedge clk);
    qa.push_back(mk(50, 1, 0, 3'd6));
    a_done = 1'b1; @(negedge clk); a_done = 1'b0;
    repeat (5) @(negedge clk);
    check("a_pre_rst_sample", a_sample, 1);
    a_rst = 1'b1; @(negedge clk);
    qa.delete();
    check("a_mid_rst_busy", a_busy, 0);
    check("a_mid_rst_rd_en", a_rd_en, 0);
    check("a_mid_rst_sample", a_sample, 0);
    check("a_mid_rst_elem", a_elem, 0);
    check("a_mid_rst_bus", |{a_train_bus, a_input_bus, a_type}, 0);
    a_rst = 1'b0;
    n_rd = 0;
    repeat (40) begin
      @(negedge clk);
      if (a_read_done || a_rd_en || a_busy) n_rd++;
    end
    check("a_post_rst_idle", n_rd, 0);
    qa.push_back(mk(50, 0, 0, 3'd3));
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    check("a_restart_sample", a_sample, 0);
    check("a_restart_elem", a_elem, 0);
    wait_rd(0, cyc, ens);
    check("a_restart_reads", ens, 32);
    @(negedge clk);
    check("a_queue_drained", qa.size(), 0);

    // instance B: four single-burst samples with labels 3,1,5,2
    qb.push_back(mk(16, 0, 0, lab_b[0]));
    b_start = 1'b1; @(negedge clk); b_start = 1'b0;
    for (int s = 0; s < 4; s++) begin
      wait_rd(1, cyc, ens);
      check($sformatf("b_s%0d_reads", s), ens, 16);
      @(negedge clk);
      if (s == 0) begin
        check("b_err_clear", b_err, 0);
        b_inf = 1'b1; @(negedge clk); b_inf = 1'b0;
        check("b_err_early_inf", b_err, 1);
      end
      n_en = 0;
      repeat (3) begin
        @(negedge clk);
        if (b_rd_en || b_read_done) n_en++;
      end
      check($sformatf("b_s%0d_wait_done", s), n_en, 0);
      if (s < 3) qb.push_back(mk(16, s + 1, 0, lab_b[s+1]));
      b_done = 1'b1; @(negedge clk); b_done = 1'b0;
    end
    check("b_wait_inf_busy", b_busy, 1);
    check("b_wait_inf_rd_en", b_rd_en, 0);
    b_inf = 1'b1; #1;
    check("b_run_done", b_run_done, 1);
    check("b_busy_falls", b_busy, 0);
    @(negedge clk); b_inf = 1'b0;
    check("b_run_done_pulse", b_run_done, 0);
    check("b_queue_drained", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
